// File: rtl/block_stream_gen_pkg.sv
// Shared token codes, ASCII constants and keyword helpers for the block stream generator.
package block_stream_gen_pkg;

  typedef enum logic [1:0] {
    TOK_SPACE = 2'b00,
    TOK_BEGIN = 2'b01,
    TOK_END   = 2'b10,
    TOK_CHAR  = 2'b11
  } tok_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [7:0] ASC_B = 8'h62;
  localparam logic [7:0] ASC_E = 8'h65;
  localparam logic [7:0] ASC_G = 8'h67;
  localparam logic [7:0] ASC_I = 8'h69;
  localparam logic [7:0] ASC_N = 8'h6E;
  localparam logic [7:0] ASC_D = 8'h64;
  localparam logic [7:0] CASE_BIT = 8'h20;

  localparam logic [2:0] LEN_BEGIN = 3'd6;
  localparam logic [2:0] LEN_END   = 3'd4;
  localparam logic [2:0] LEN_ONE   = 3'd1;

  function automatic logic [2:0] tok_len(input tok_e t);
    case (t)
      TOK_BEGIN: tok_len = LEN_BEGIN;
      TOK_END:   tok_len = LEN_END;
      default:   tok_len = LEN_ONE;
    endcase
  endfunction

  // Lowercase keyword letter i; positions past the keyword return 0.
  function automatic logic [7:0] kw_letter(input tok_e t, input logic [2:0] i);
    kw_letter = 8'h00;
    if (t == TOK_BEGIN) begin
      case (i)
        3'd0:    kw_letter = ASC_B;
        3'd1:    kw_letter = ASC_E;
        3'd2:    kw_letter = ASC_G;
        3'd3:    kw_letter = ASC_I;
        3'd4:    kw_letter = ASC_N;
        default: kw_letter = 8'h00;
      endcase
    end else if (t == TOK_END) begin
      case (i)
        3'd0:    kw_letter = ASC_E;
        3'd1:    kw_letter = ASC_N;
        3'd2:    kw_letter = ASC_D;
        default: kw_letter = 8'h00;
      endcase
    end
  endfunction

endpackage

// File: rtl/block_stream_gen_keyword_rom.sv
// Combinational byte lookup: keyword letters with per-letter case, separator, or raw char.
module block_stream_gen_keyword_rom
  import block_stream_gen_pkg::*;
#(
  parameter logic [7:0] SEP = 8'h20
) (
  input  logic [1:0] tok_type,
  input  logic [2:0] idx,
  input  logic [4:0] case_mask,
  input  logic [7:0] tok_char,
  output logic [7:0] data
);

  tok_e       t;
  logic [7:0] letter;
  logic       upper;

  assign t = tok_e'(tok_type);

  always_comb begin
    letter = kw_letter(t, idx);
    upper  = 1'b0;
    data   = SEP;
    case (t)
      TOK_BEGIN: begin
        if (idx < 3'd5) begin
          upper = case_mask[idx];
          data  = upper ? (letter & ~CASE_BIT) : letter;
        end
      end
      // Only mask bits 0..2 are reachable for END.
      TOK_END: begin
        if (idx < 3'd3) begin
          upper = case_mask[idx];
          data  = upper ? (letter & ~CASE_BIT) : letter;
        end
      end
      TOK_CHAR: data = tok_char;
      default:  data = SEP;
    endcase
  end

endmodule

// File: rtl/block_stream_gen.sv
// Token-to-ASCII stream generator with begin/end nesting depth and sticky error tracking.
module block_stream_gen
  import block_stream_gen_pkg::*;
#(
  parameter int         DEPTH_W = 8,
  parameter logic [7:0] SEP     = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic [1:0]         tok_type,
  input  logic [7:0]         tok_char,
  input  logic [4:0]         case_mask,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_e     state;
  logic [2:0] idx;
  tok_e       cur_type;
  logic [7:0] cur_char;
  logic [4:0] cur_mask;
  logic [7:0] rom_byte;
  logic       last;
  logic       accept;
  logic       inc_pend;
  logic       dec_pend;

  block_stream_gen_keyword_rom #(.SEP(SEP)) u_rom (
    .tok_type  (cur_type),
    .idx       (idx),
    .case_mask (cur_mask),
    .tok_char  (cur_char),
    .data      (rom_byte)
  );

  assign last      = (state == ST_EMIT) && (idx == tok_len(cur_type) - 3'd1);
  assign tok_ready = (state == ST_IDLE) || last;
  assign accept    = tok_valid && tok_ready;
  assign balanced  = (depth == '0) && !err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cur_type  <= TOK_SPACE;
      cur_char  <= 8'h00;
      cur_mask  <= 5'd0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      depth     <= '0;
      err       <= 1'b0;
      inc_pend  <= 1'b0;
      dec_pend  <= 1'b0;
    end else begin
      if (state == ST_EMIT) begin
        out       <= rom_byte;
        out_valid <= 1'b1;
      end else begin
        out       <= 8'h00;
        out_valid <= 1'b0;
      end

      // Depth moves one edge after the separator is on out, when the checker samples it.
      inc_pend <= last && (cur_type == TOK_BEGIN);
      dec_pend <= last && (cur_type == TOK_END);
      if (inc_pend) begin
        if (depth == DEPTH_MAX) err <= 1'b1;
        else                    depth <= depth + DEPTH_W'(1);
      end
      if (dec_pend) begin
        if (depth == '0) err <= 1'b1;
        else             depth <= depth - DEPTH_W'(1);
      end

      if (accept) begin
        state    <= ST_EMIT;
        idx      <= 3'd0;
        cur_type <= tok_e'(tok_type);
        cur_char <= tok_char;
        cur_mask <= case_mask;
      end else if (state == ST_EMIT) begin
        if (last) begin
          state <= ST_IDLE;
          idx   <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen: default instance plus a DEPTH_W=2 instance on shared inputs.
module tb_block_stream_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       tok_valid;
  logic [1:0] tok_type;
  logic [7:0] tok_char;
  logic [4:0] case_mask;

  logic       tok_ready, out_valid, balanced, err;
  logic [7:0] out_b;
  logic [7:0] depth;

  logic       s_ready, s_valid, s_balanced, s_err;
  logic [7:0] s_out;
  logic [1:0] s_depth;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_stream_gen dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_char(tok_char), .case_mask(case_mask),
    .out(out_b), .out_valid(out_valid), .depth(depth), .balanced(balanced), .err(err)
  );

  block_stream_gen #(.DEPTH_W(2)) dut_small (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(s_ready),
    .tok_type(tok_type), .tok_char(tok_char), .case_mask(case_mask),
    .out(s_out), .out_valid(s_valid), .depth(s_depth), .balanced(s_balanced), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] b);
    tick();
    chk({tag, "_out"}, 32'(out_b), 32'(b));
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; tok_valid = 1'b0; tok_type = 2'b00; tok_char = 8'h00; case_mask = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_b), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bal", 32'(balanced), 32'd1);
    chk("rst_rdy", 32'(tok_ready), 32'd1);

    // 1/2: BEGIN mask 00011, END held back-to-back
    reset = 1'b0; tok_valid = 1'b1; tok_type = 2'b01; case_mask = 5'b00011;
    tick();
    chk("t1_acc_vld", 32'(out_valid), 32'd0);
    chk("t1_busy_rdy", 32'(tok_ready), 32'd0);
    tok_type = 2'b10; case_mask = 5'b00000;
    exp_byte("t1_B", "B");
    exp_byte("t1_E", "E");
    exp_byte("t1_g", "g");
    exp_byte("t1_i", "i");
    exp_byte("t1_n", "n");
    chk("t1_last_rdy", 32'(tok_ready), 32'd1);
    exp_byte("t1_sp", " ");
    chk("t1_depth_pre", 32'(depth), 32'd0);
    tok_valid = 1'b0;
    exp_byte("t2_e", "e");
    chk("t1_depth", 32'(depth), 32'd1);
    chk("t1_bal", 32'(balanced), 32'd0);
    exp_byte("t2_n", "n");
    exp_byte("t2_d", "d");
    exp_byte("t2_sp", " ");
    tick();
    chk("t2_idle_vld", 32'(out_valid), 32'd0);
    chk("t2_idle_out", 32'(out_b), 32'd0);
    chk("t2_depth", 32'(depth), 32'd0);
    chk("t2_bal", 32'(balanced), 32'd1);

    // 3: END at depth 0 (mask bits 3,4 must be ignored), then BEGIN+END
    chk("t3_rdy", 32'(tok_ready), 32'd1);
    tok_valid = 1'b1; tok_type = 2'b10; case_mask = 5'b11010;
    tick();
    tok_valid = 1'b0;
    exp_byte("t3_e", "e");
    exp_byte("t3_N", "N");
    exp_byte("t3_d", "d");
    exp_byte("t3_sp", " ");
    tick();
    chk("t3_vld", 32'(out_valid), 32'd0);
    chk("t3_depth", 32'(depth), 32'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_bal", 32'(balanced), 32'd0);
    tok_valid = 1'b1; tok_type = 2'b01; case_mask = 5'b00000;
    tick();
    tok_valid = 1'b0;
    exp_byte("t3b_b", "b");
    exp_byte("t3b_e", "e");
    exp_byte("t3b_g", "g");
    exp_byte("t3b_i", "i");
    exp_byte("t3b_n", "n");
    exp_byte("t3b_sp", " ");
    tok_valid = 1'b1; tok_type = 2'b10;
    tick();
    tok_valid = 1'b0;
    chk("t3b_depth", 32'(depth), 32'd1);
    exp_byte("t3e_e", "e");
    exp_byte("t3e_n", "n");
    exp_byte("t3e_d", "d");
    exp_byte("t3e_sp", " ");
    tick();
    chk("t3e_depth", 32'(depth), 32'd0);
    chk("t3e_err", 32'(err), 32'd1);

    // 4: CHAR 'a', SPACE, CHAR 'Z' back-to-back
    tok_valid = 1'b1; tok_type = 2'b11; tok_char = "a"; case_mask = 5'b11111;
    tick();
    chk("t4_rdy", 32'(tok_ready), 32'd1);
    tok_type = 2'b00; tok_char = "q";
    exp_byte("t4_a", "a");
    tok_type = 2'b11; tok_char = "Z";
    exp_byte("t4_sp", " ");
    tok_valid = 1'b0;
    exp_byte("t4_Z", "Z");
    tick();
    chk("t4_vld_off", 32'(out_valid), 32'd0);
    chk("t4_depth", 32'(depth), 32'd0);

    // 5: reset on 3rd byte of BEGIN
    tok_valid = 1'b1; tok_type = 2'b01; case_mask = 5'b00000;
    tick();
    tok_valid = 1'b0;
    exp_byte("t5_b", "b");
    exp_byte("t5_e", "e");
    exp_byte("t5_g", "g");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out", 32'(out_b), 32'd0);
    chk("t5_vld", 32'(out_valid), 32'd0);
    chk("t5_depth", 32'(depth), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_rdy", 32'(tok_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_quiet", 32'(out_valid), 32'd0);
    end

    // 6: four BEGINs on DEPTH_W=2 instance
    tok_valid = 1'b1; tok_type = 2'b01; case_mask = 5'b00000;
    tick();
    for (int n = 0; n < 4; n++) begin
      exp_byte("t6_b", "b");
      if (n > 0) chk("t6_sdepth", 32'(s_depth), 32'(n));
      exp_byte("t6_e", "e");
      exp_byte("t6_g", "g");
      exp_byte("t6_i", "i");
      exp_byte("t6_n", "n");
      exp_byte("t6_sp", " ");
      if (n == 2) begin
        tick();
        tok_valid = 1'b0;
        chk("t6_b4", 32'(out_b), 32'("b"));
        chk("t6_sdepth3", 32'(s_depth), 32'd3);
        chk("t6_serr_pre", 32'(s_err), 32'd0);
        exp_byte("t6_e4", "e");
        exp_byte("t6_g4", "g");
        exp_byte("t6_i4", "i");
        exp_byte("t6_n4", "n");
        exp_byte("t6_sp4", " ");
        break;
      end
    end
    tick();
    chk("t6_sdepth_hold", 32'(s_depth), 32'd3);
    chk("t6_serr", 32'(s_err), 32'd1);
    chk("t6_sbal", 32'(s_balanced), 32'd0);
    chk("t6_depth_big", 32'(depth), 32'd4);
    chk("t6_err_big", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
